univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised N-bit universal register; successor to the team's plain D register (clk, d, q).
- Adds synchronous active-low reset, clear, preset, hold, parallel load, logical shifts and rotates.
- Adds an autonomous parallel-to-serial burst (LSB first) with a busy/done handshake.
- Used as a general storage, shift or serialiser element in datapaths.

Parameters:
- N, 8, register width in bits; legal range N >= 2.
- CW, $clog2(N), burst counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- op  input  3  operation select when idle (encoding below)
- d  input  N  parallel data for LOAD and burst start
- sin_l  input  1  serial fill bit entering at MSB on SHR
- sin_r  input  1  serial fill bit entering at LSB on SHL
- ser_start  input  1  request a serial burst of d, sampled when idle
- q  output  N  register contents (registered)
- sout  output  1  serial data; equals busy ? q[0] : 0 (combinational from registers)
- busy  output  1  high while a burst is in progress (registered)
- done  output  1  one-cycle pulse after a burst completes normally (registered)

Behaviour:
- Reset: rst_n=0 at an edge forces q=0, busy=0, done=0, cnt=0. It overrides everything, including a burst in flight; no done is produced.
- Priority at each edge: rst_n, then abort (op CLR/SET while busy), then burst step while busy, then ser_start when idle, then op when idle.
- op encoding when idle (and when ser_start=0):
  - 000 HOLD: q unchanged.
  - 001 LOAD: q<=d.
  - 010 SHL: q<={q[N-2:0],sin_r}.
  - 011 SHR: q<={sin_l,q[N-1:1]}.
  - 100 ROL: q<={q[N-2:0],q[N-1]}.
  - 101 ROR: q<={q[0],q[N-1:1]}.
  - 110 CLR: q<=0.
  - 111 SET: q<={N{1'b1}}.
- States: IDLE (busy=0) and SER (busy=1).
- IDLE with ser_start=1: q<=d, cnt<=0, busy<=1. op is ignored that cycle.
- SER each edge: q<={1'b0,q[N-1:1]}.
  - If cnt==N-1: busy<=0, done<=1, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- Burst timing: busy is high for exactly N cycles. sout presents d[0] in the first busy cycle through d[N-1] in the Nth. done is high in the cycle after the last busy cycle. q=0 at that point.
- done is high for exactly one cycle; otherwise 0. done may coincide with a new ser_start, which is accepted (back-to-back bursts, no gap cycle required).
- While busy:
  - ser_start is ignored.
  - op values 000–101 are ignored.
  - op=CLR or SET aborts: q<=0 or all-ones, busy<=0, cnt<=0, done stays 0.
- sout=0 whenever busy=0.
- No latency beyond one edge for any op.
- Unknown/X inputs are not required to be handled.

Test Plan:
1. Reset: rst_n=0 for 2 edges with op=SET, ser_start=1 -> q=0x00, busy=0, done=0, sout=0.
2. Shifts and rotates, applied in sequence:
   - LOAD d=0xA5 -> q=0xA5.
   - SHL sin_r=1 -> q=0x4B.
   - SHR sin_l=1 -> q=0xA5.
   - ROL -> q=0x4B.
   - ROR -> q=0xA5.
3. Set/clear/hold:
   - SET -> q=0xFF.
   - CLR -> q=0x00.
   - LOAD 0x3C, then HOLD for 3 cycles with d toggling 0xFF/0x00 -> q stays 0x3C.
4. Burst: ser_start=1, d=0xB4.
   - Over the 8 busy cycles sout=0,0,1,0,1,1,0,1.
   - busy high exactly 8 cycles; done high for 1 cycle after; q=0x00.
   - Repeat with ser_start asserted in the done cycle -> second burst starts with no gap.
5. Abort and ignore: ser_start, d=0xFF.
   - In busy cycle 2, ser_start=1, d=0x00 -> ignored; sout continues 1.
   - In busy cycle 3, op=SET -> next cycle q=0xFF, busy=0; done never asserted.
6. Reset mid-burst: rst_n=0 during busy cycle 5 of a 0xC3 burst -> q=0, busy=0, sout=0, no done pulse.

Source files
------------

// File: rtl/univ_shift_reg.sv
// N-bit universal register: hold/load/shift/rotate/clear/preset plus an
// autonomous LSB-first parallel-to-serial burst with busy/done handshake.
module univ_shift_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   op,
  input  logic [N-1:0] d,
  input  logic         sin_l,
  input  logic         sin_r,
  input  logic         ser_start,
  output logic [N-1:0] q,
  output logic         sout,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_SET  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  q_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done_nxt;

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    if (state == SER) begin
      // CLR/SET are the only ops honoured mid-burst; they abort without done
      if (op == OP_CLR || op == OP_SET) begin
        q_nxt     = (op == OP_SET) ? '1 : '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end else begin
        q_nxt = {1'b0, q[N-1:1]};
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    end else if (ser_start) begin
      q_nxt     = d;
      cnt_nxt   = '0;
      state_nxt = SER;
    end else begin
      case (op)
        OP_HOLD: q_nxt = q;
        OP_LOAD: q_nxt = d;
        OP_SHL:  q_nxt = {q[N-2:0], sin_r};
        OP_SHR:  q_nxt = {sin_l, q[N-1:1]};
        OP_ROL:  q_nxt = {q[N-2:0], q[N-1]};
        OP_ROR:  q_nxt = {q[0], q[N-1:1]};
        OP_CLR:  q_nxt = '0;
        OP_SET:  q_nxt = '1;
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  assign busy = (state == SER);
  assign sout = busy & q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (N=8): expected outputs are queued
// as each cycle's stimulus is driven and compared after the clock edge.
module tb_univ_shift_reg;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   op;
  logic [N-1:0] d;
  logic         sin_l, sin_r, ser_start;
  logic [N-1:0] q;
  logic         sout, busy, done;

  typedef struct packed {
    logic [N-1:0] q;
    logic         busy;
    logic         done;
    logic         sout;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  univ_shift_reg #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .d         (d),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .ser_start (ser_start),
    .q         (q),
    .sout      (sout),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input string tag, input logic rn, input logic [2:0] o,
                      input logic [N-1:0] dd, input logic sl, input logic sr,
                      input logic ss, input logic [N-1:0] eq, input logic eb,
                      input logic ed, input logic es);
    exp_t e;
    rst_n = rn; op = o; d = dd; sin_l = sl; sin_r = sr; ser_start = ss;
    e.q = eq; e.busy = eb; e.done = ed; e.sout = es;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({tag, ".q"},    32'(q),    32'(e.q));
    check_val({tag, ".busy"}, 32'(busy), 32'(e.busy));
    check_val({tag, ".done"}, 32'(done), 32'(e.done));
    check_val({tag, ".sout"}, 32'(sout), 32'(e.sout));
  endtask

  // Full burst: start edge, seven further busy edges, then the done cycle.
  task automatic run_burst(input string tag, input logic [N-1:0] dd);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v = dd >> i;
      step($sformatf("%s_b%0d", tag, i), 1'b1, 3'b000, (i == 0) ? dd : 8'h00,
           1'b0, 1'b0, (i == 0), v, 1'b1, 1'b0, dd[i]);
    end
    step({tag, "_done"}, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; op = 3'b111; d = '0; sin_l = 1'b0; sin_r = 1'b0; ser_start = 1'b1;
    @(negedge clk);

    step("rst0", 1'b0, 3'b111, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step("rst1", 1'b0, 3'b111, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

    step("load", 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    step("shl",  1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0);
    step("shr",  1'b1, 3'b011, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    step("rol",  1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0);
    step("ror",  1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    step("shl0", 1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 1'b0, 8'h4A, 1'b0, 1'b0, 1'b0);
    step("shr0", 1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 1'b0, 8'h25, 1'b0, 1'b0, 1'b0);

    step("set",  1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    step("clr",  1'b1, 3'b110, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step("ld3c", 1'b1, 3'b001, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    step("hld0", 1'b1, 3'b000, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    step("hld1", 1'b1, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    step("hld2", 1'b1, 3'b000, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

    run_burst("bst1", 8'hB4);
    run_burst("bst2", 8'hB4);
    step("post", 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    step("ab_s",  1'b1, 3'b000, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    step("ab_1",  1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1);
    step("ab_ig", 1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3F, 1'b1, 1'b0, 1'b1);
    step("ab_set",1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    step("ab_h",  1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);

    step("ac_s",  1'b1, 3'b000, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    step("ac_clr",1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step("ac_h",  1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    step("mr_s",  1'b1, 3'b000, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1);
    step("mr_1",  1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h61, 1'b1, 1'b0, 1'b1);
    step("mr_2",  1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0);
    step("mr_3",  1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h18, 1'b1, 1'b0, 1'b0);
    step("mr_4",  1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0C, 1'b1, 1'b0, 1'b0);
    step("mr_rst",1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step($sformatf("mr_idle%0d", i), 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0,
           8'h00, 1'b0, 1'b0, 1'b0);

    run_burst("bst3", 8'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
